// File: rtl/pc_seq.sv
// pc_seq: writable instruction store sequenced by a RUN/IDLE/HALT machine.
// Presents registered instructions and their fetch address to the mode-1 CPU datapath.
module pc_seq #(
    parameter int                 ADDR_W    = 4,
    parameter int                 INSTR_W   = 8,
    parameter logic [INSTR_W-1:0] HALT_WORD = 8'hFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ena,
    input  logic               start,
    input  logic [ADDR_W-1:0]  loop_end,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted,
    output logic               busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;
    logic               r_valid;
    logic               r_busy;
    logic               r_halted;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] w_fetch;
    logic               w_halt_hit;
    logic               w_fetch_en;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [ADDR_W-1:0]  w_pc_out_nxt;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_halted_nxt;

    // The fetch reads the pre-edge word, so a same-cycle write returns the old value.
    assign w_fetch    = r_mem[r_pc];
    assign w_halt_hit = (w_fetch == HALT_WORD);

    // Instruction store write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // State, program counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= {ADDR_W{1'b0}};
            r_instr  <= {INSTR_W{1'b0}};
            r_pc_out <= {ADDR_W{1'b0}};
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next state and next pc; start outranks stall, halt and jump.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RUN: begin
                if (start) begin
                    w_pc_nxt = {ADDR_W{1'b0}};
                end else if (ena) begin
                    if (w_halt_hit) begin
                        w_state_nxt = S_HALT;
                    end else if (jump_en) begin
                        w_pc_nxt = jump_addr;
                    end else if (r_pc == loop_end) begin
                        w_pc_nxt = {ADDR_W{1'b0}};
                    end else begin
                        w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output next values: a fetch happens only in RUN with ena and no restart.
    always_comb begin
        w_fetch_en   = (r_state == S_RUN) && !start && ena;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        if (w_fetch_en) begin
            w_instr_nxt  = w_fetch;
            w_pc_out_nxt = r_pc;
        end else begin
            w_instr_nxt  = r_instr;
            w_pc_out_nxt = r_pc_out;
        end
        w_valid_nxt  = w_fetch_en;
        w_busy_nxt   = (w_state_nxt == S_RUN);
        w_halted_nxt = (w_state_nxt == S_HALT);
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc_out;
    assign halted      = r_halted;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: table vectors, directed corner sequences and randomized traffic
// checked against a behavioural sequencer model.
module tb_pc_seq;

    logic       clock;
    logic       reset;
    logic       ena;
    logic       start;
    logic [3:0] loop_end;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic [3:0] pc_out;
    logic       halted;
    logic       busy;

    int errors = 0;
    int checks = 0;

    pc_seq dut (
        .clock(clock), .reset(reset), .ena(ena), .start(start),
        .loop_end(loop_end), .jump_en(jump_en), .jump_addr(jump_addr),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .pc_out(pc_out),
        .halted(halted), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: 0 idle, 1 run, 2 halt
    int         m_state = 0;
    int         m_pc    = 0;
    logic [7:0] m_mem [16];
    logic [7:0] m_instr = 8'h00;
    int         m_pcout = 0;
    logic       m_valid = 1'b0;

    task automatic model_edge();
        logic [7:0] word;
        word = m_mem[m_pc];
        if (reset) begin
            m_state = 0; m_pc = 0; m_instr = 8'h00; m_pcout = 0; m_valid = 1'b0;
        end else if (m_state == 1) begin
            m_valid = 1'b0;
            if (start) begin
                m_pc = 0;
            end else if (ena) begin
                m_instr = word; m_pcout = m_pc; m_valid = 1'b1;
                if (word == 8'hFF) m_state = 2;
                else if (jump_en) m_pc = int'(jump_addr);
                else if (m_pc == int'(loop_end)) m_pc = 0;
                else m_pc = (m_pc + 1) % 16;
            end
        end else begin
            m_valid = 1'b0;
            if (start) begin
                m_state = 1; m_pc = 0;
            end
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model.instr_out", 32'(instr_out), 32'(m_instr));
        chk("model.instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("model.pc_out", 32'(pc_out), 32'(m_pcout));
        chk("model.busy", 32'(busy), 32'(m_state == 1));
        chk("model.halted", 32'(halted), 32'(m_state == 2));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic quiet();
        reset = 1'b0; ena = 1'b0; start = 1'b0; jump_en = 1'b0;
        jump_addr = 4'd0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'h00;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       st;
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] lend;
        logic [7:0] e_instr;
        logic       e_valid;
        logic [3:0] e_pc;
        logic       e_busy;
        logic       e_halt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        quiet();
        loop_end = 4'd3;

        // Default program load and loop
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h03, 4'd3, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'h22, 4'd3, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'h45, 4'd3, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'h00, 4'd3, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 4'd3, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h03, 1'b1, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h22, 1'b1, 4'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h45, 1'b1, 4'd2, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h00, 1'b1, 4'd3, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h03, 1'b1, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 8'h22, 1'b1, 4'd1, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; ena = tbl[i].en; start = tbl[i].st;
            prog_we = tbl[i].we; prog_addr = tbl[i].waddr; prog_data = tbl[i].wdata;
            loop_end = tbl[i].lend;
            step();
            chk("tbl.instr_out", 32'(instr_out), 32'(tbl[i].e_instr));
            chk("tbl.instr_valid", 32'(instr_valid), 32'(tbl[i].e_valid));
            chk("tbl.pc_out", 32'(pc_out), 32'(tbl[i].e_pc));
            chk("tbl.busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl.halted", 32'(halted), 32'(tbl[i].e_halt));
        end

        // Full-depth wrap with an all-zero store
        quiet(); reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = 8'h00; step();
        end
        quiet(); loop_end = 4'd15; start = 1'b1; step();
        start = 1'b0; ena = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("wrap.pc_out", 32'(pc_out), 32'(i % 16));
            chk("wrap.valid", 32'(instr_valid), 32'd1);
            chk("wrap.halted", 32'(halted), 32'd0);
        end

        // Halt word at address 2
        quiet(); prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hFF; reset = 1'b1; step();
        quiet(); start = 1'b1; step();
        start = 1'b0; ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt.pc_out", 32'(pc_out), 32'(i));
        end
        chk("halt.word", 32'(instr_out), 32'hFF);
        chk("halt.valid_once", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt.halted", 32'(halted), 32'd1);
            chk("halt.busy", 32'(busy), 32'd0);
            chk("halt.valid", 32'(instr_valid), 32'd0);
            chk("halt.hold_instr", 32'(instr_out), 32'hFF);
            chk("halt.hold_pc", 32'(pc_out), 32'd2);
        end
        start = 1'b1; step();
        chk("restart.busy", 32'(busy), 32'd1);
        chk("restart.halted", 32'(halted), 32'd0);
        start = 1'b0; step();
        chk("restart.pc_out", 32'(pc_out), 32'd0);
        chk("restart.valid", 32'(instr_valid), 32'd1);
        quiet(); reset = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'h00; step();

        // Jump, then stall with an ignored jump
        quiet(); loop_end = 4'd15; start = 1'b1; step();
        start = 1'b0; ena = 1'b1; step();
        jump_en = 1'b1; jump_addr = 4'd5; step();
        chk("jump.src_pc", 32'(pc_out), 32'd1);
        jump_en = 1'b0; step();
        chk("jump.dst_pc", 32'(pc_out), 32'd5);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            jump_en = (i == 1); jump_addr = 4'd9;
            step();
            chk("stall.pc_out", 32'(pc_out), 32'd5);
            chk("stall.valid", 32'(instr_valid), 32'd0);
        end
        jump_en = 1'b0; ena = 1'b1; step();
        chk("stall.resume_pc", 32'(pc_out), 32'd6);

        // Read-before-write on the fetched address
        quiet(); loop_end = 4'd3; start = 1'b1; step();
        start = 1'b0; ena = 1'b1; step();
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h55; step();
        chk("rbw.old_word", 32'(instr_out), 32'h00);
        chk("rbw.pc", 32'(pc_out), 32'd1);
        prog_we = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rbw.new_pc", 32'(pc_out), 32'd1);
        chk("rbw.new_word", 32'(instr_out), 32'h55);

        // Reset mid-run at pc=2, store preserved
        reset = 1'b1; ena = 1'b1; step();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.instr", 32'(instr_out), 32'h00);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.pc_out", 32'(pc_out), 32'd0);
        reset = 1'b0; start = 1'b1; step();
        start = 1'b0; step(); step();
        chk("rst.kept_word", 32'(instr_out), 32'h55);

        // Randomized traffic against the model
        quiet();
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom % 100) == 0;
            start     = ($urandom % 30) == 0;
            ena       = ($urandom % 4) != 0;
            jump_en   = ($urandom % 8) == 0;
            jump_addr = 4'($urandom);
            prog_we   = ($urandom % 5) == 0;
            prog_addr = 4'($urandom);
            prog_data = (($urandom % 6) == 0) ? 8'hFF : 8'($urandom);
            if (($urandom % 50) == 0) loop_end = 4'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised successor to the mode-1 program counter and ROM.
- Holds a writable instruction store of DEPTH words and sequences through it with a RUN/IDLE/HALT state machine.
- Supports a runtime loop-end address, external jumps, stall (ena) and a halt-word stop.
- Feeds registered instructions ([7:5] opcode, [4:0] operand at the default width) to the CPU datapath when the CPU is in mode 1.

Parameters:
- ADDR_W, 4: PC width. DEPTH = 2**ADDR_W words.
- INSTR_W, 8: instruction width.
- HALT_WORD, 8'hFF: fetched word that stops sequencing. Width is INSTR_W.

Ports:
- clock, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high.
- ena, input, 1: fetch enable. 0 stalls the fetch in RUN.
- start, input, 1: begin or restart execution from address 0.
- loop_end, input, ADDR_W: last address before wrap to 0.
- jump_en, input, 1: redirect the next fetch.
- jump_addr, input, ADDR_W: jump target.
- prog_we, input, 1: instruction store write strobe.
- prog_addr, input, ADDR_W: write address.
- prog_data, input, INSTR_W: write data.
- instr_out, output, INSTR_W: registered fetched instruction.
- instr_valid, output, 1: instr_out is new this cycle (1-cycle pulse per fetch).
- pc_out, output, ADDR_W: address that instr_out was fetched from.
- halted, output, 1: state is HALT.
- busy, output, 1: state is RUN.

Behaviour:
- Reset is synchronous active-high. On a reset edge:
  - state=IDLE, internal pc=0, instr_out=0, instr_valid=0, pc_out=0, halted=0, busy=0.
  - Instruction store contents are NOT cleared by reset. Power-up/initial contents are all 0.
  - Reset asserted mid-RUN aborts: next cycle shows IDLE and outputs at their reset values.
- Store writes:
  - prog_we=1 writes prog_data to prog_addr on the edge, in any state.
  - Same-cycle write and fetch of the same address: the fetch returns the OLD word (read-before-write). The new word is visible from the next fetch.
- State IDLE:
  - start=1 -> RUN with pc=0. No fetch occurs in the transition cycle.
  - jump_en is ignored.
- State RUN, ena=1, each edge:
  - instr_out <= mem[pc]; pc_out <= pc; instr_valid <= 1.
  - Next pc, in priority order:
    1. mem[pc]==HALT_WORD -> pc holds, state -> HALT. The halt word itself is presented with instr_valid=1.
    2. jump_en=1 -> jump_addr.
    3. pc==loop_end -> 0.
    4. Otherwise pc+1, modulo DEPTH (DEPTH-1 wraps to 0 even if loop_end is never reached).
  - loop_end=0 re-fetches address 0 every cycle.
- State RUN, ena=0:
  - pc, instr_out and pc_out hold; instr_valid <= 0.
  - jump_en is ignored while stalled (not latched).
- State RUN, start=1: restart with pc=0 on that edge. The cycle's fetch is suppressed (instr_valid=0). start has priority over ena, jump_en and halt.
- State HALT:
  - halted=1, instr_valid=0, instr_out and pc_out hold the halt word and its address.
  - start=1 -> RUN with pc=0, halted=0 the following cycle.
- Latency: start edge -> first instr_valid is 2 edges, given ena=1 on the second edge. Thereafter one instruction per enabled cycle.
- Status outputs: busy and halted are registered state decodes. IDLE gives busy=0 and halted=0.

Test Plan:
- Load default program: mem[0..3] = 8'h03 (ADD 3), 8'h22 (SUB 2), 8'h45 (MUL 5), 8'h00 (NOP); loop_end=3, start pulse, ena=1 -> instr_out sequence 03,22,45,00,03,22... with pc_out 0,1,2,3,0,1; instr_valid=1 every cycle after the first fetch.
- loop_end=15, mem all 0, run 17 fetches -> pc_out goes 0..15 then wraps to 0; no halt.
- Write HALT_WORD (8'hFF) at mem[2], run -> fetches at 0,1,2; instr_out=FF, pc_out=2, instr_valid=1 once; then halted=1, busy=0, instr_valid=0 held for 10 cycles; start pulse -> refetch from 0.
- Assert jump_en with jump_addr=5 during the fetch of address 1 -> next pc_out=5. Hold ena=0 for 3 cycles -> outputs frozen, instr_valid=0, no pc advance. jump_en asserted while ena=0 -> no effect.
- Write mem[1]=8'h55 in the same cycle as the fetch of address 1 -> that fetch returns the old value; the next lap returns 8'h55.
- Assert reset for one cycle mid-RUN at pc=2 -> next cycle state IDLE, all outputs 0; memory contents preserved (next start fetches the same words).
